// File: rtl/alu_checker.sv
// ALU result checker: accepts one ALU operation at a time, works out the
// expected result/overflow/zero, waits DUT_LATENCY cycles for the ALU under
// test, then compares and keeps saturating pass/fail counts plus a snapshot
// of the first failing operation.
module alu_checker #(
   parameter int DUT_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             chk_valid,
   output logic             chk_ready,
   input  logic [3:0]       chk_ctrl,
   input  logic [31:0]      chk_oper1,
   input  logic [31:0]      chk_oper2,
   input  logic [31:0]      dut_result,
   input  logic             dut_overflow,
   input  logic             dut_zero,
   output logic             chk_done,
   output logic             chk_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             fail_seen,
   output logic [3:0]       fail_ctrl,
   output logic [31:0]      fail_exp,
   output logic [31:0]      fail_act
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CHECK
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(DUT_LATENCY - 1);

   state_t             state_q;
   logic [3:0]         wait_q;
   logic [3:0]         ctrl_q;
   logic [31:0]        expRes_q;
   logic               expOvf_q;
   logic               expZero_q;
   logic [CNT_W-1:0]   passCnt_q;
   logic [CNT_W-1:0]   failCnt_q;
   logic               failSeen_q;
   logic [3:0]         failCtrl_q;
   logic [31:0]        failExp_q;
   logic [31:0]        failAct_q;

   logic [31:0]        expRes_d;
   logic               expOvf_d;
   logic               expZero_d;
   logic [31:0]        sum;
   logic [31:0]        diff;
   logic               allMatch;

   assign sum  = chk_oper1 + chk_oper2;
   assign diff = chk_oper1 - chk_oper2;

   // Expected ALU behaviour for the operation currently on the inputs; only
   // captured on the accept edge, so later input changes are harmless.
   always_comb begin
      expRes_d = 32'h0;
      expOvf_d = 1'b0;
      unique case (chk_ctrl)
         4'd0: begin
            expRes_d = sum;
            expOvf_d = (chk_oper1[31] == chk_oper2[31]) && (sum[31] != chk_oper1[31]);
         end
         4'd1: begin
            expRes_d = diff;
            expOvf_d = (chk_oper1[31] != chk_oper2[31]) && (diff[31] != chk_oper1[31]);
         end
         4'd2: expRes_d = chk_oper1 & chk_oper2;
         4'd3: expRes_d = chk_oper1 | chk_oper2;
         4'd4: expRes_d = chk_oper1 ^ chk_oper2;
         4'd5: expRes_d = ~(chk_oper1 | chk_oper2);
         4'd6: expRes_d = {31'h0, $signed(chk_oper1) < $signed(chk_oper2)};
         4'd7: expRes_d = {31'h0, chk_oper1 < chk_oper2};
         default: expRes_d = 32'h0;
      endcase
      expZero_d = (expRes_d == 32'h0);
   end

   assign allMatch  = (dut_result == expRes_q) && (dut_overflow == expOvf_q) &&
                      (dut_zero == expZero_q);
   assign chk_ready = (state_q == IDLE);
   assign chk_done  = (state_q == CHECK);
   assign chk_pass  = (state_q == CHECK) && allMatch;

   assign pass_cnt  = passCnt_q;
   assign fail_cnt  = failCnt_q;
   assign fail_seen = failSeen_q;
   assign fail_ctrl = failCtrl_q;
   assign fail_exp  = failExp_q;
   assign fail_act  = failAct_q;

   // Sequencer: accept in IDLE, count out the ALU latency in WAIT, then
   // score the comparison in CHECK and update counters and the failure snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_q     <= 4'h0;
         ctrl_q     <= 4'h0;
         expRes_q   <= 32'h0;
         expOvf_q   <= 1'b0;
         expZero_q  <= 1'b0;
         passCnt_q  <= '0;
         failCnt_q  <= '0;
         failSeen_q <= 1'b0;
         failCtrl_q <= 4'h0;
         failExp_q  <= 32'h0;
         failAct_q  <= 32'h0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (chk_valid) begin
                  ctrl_q    <= chk_ctrl;
                  expRes_q  <= expRes_d;
                  expOvf_q  <= expOvf_d;
                  expZero_q <= expZero_d;
                  wait_q    <= WAIT_LOAD;
                  state_q   <= (DUT_LATENCY > 1) ? WAIT : CHECK;
               end
            end
            WAIT: begin
               wait_q <= wait_q - 4'd1;
               if (wait_q <= 4'd1) begin
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               state_q <= IDLE;
               if (allMatch) begin
                  if (passCnt_q != '1) begin
                     passCnt_q <= passCnt_q + CNT_W'(1);
                  end
               end else begin
                  if (failCnt_q != '1) begin
                     failCnt_q <= failCnt_q + CNT_W'(1);
                  end
                  if (!failSeen_q) begin
                     failSeen_q <= 1'b1;
                     failCtrl_q <= ctrl_q;
                     failExp_q  <= expRes_q;
                     failAct_q  <= dut_result;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: two instances (latency 1 / 16-bit counters and
// latency 4 / 4-bit counters) sharing operand and ALU-output stimulus, with
// a behavioural ALU model and a scoreboard of counters and failure snapshot.
module tb_alu_checker;

   logic        clk = 1'b0;
   logic [1:0]  rstN;
   logic [1:0]  valid;
   logic [3:0]  chkCtrl;
   logic [31:0] oper1;
   logic [31:0] oper2;
   logic [31:0] dutRes;
   logic        dutOvf;
   logic        dutZero;

   logic        readyA, doneA, passA, seenA;
   logic [15:0] passCntA, failCntA;
   logic [3:0]  fCtrlA;
   logic [31:0] fExpA, fActA;

   logic        readyB, doneB, passB, seenB;
   logic [3:0]  passCntB, failCntB;
   logic [3:0]  fCtrlB;
   logic [31:0] fExpB, fActB;

   int assertCount = 0;
   int failCount   = 0;

   // scoreboard, indexed by instance
   int          latency[2]  = '{1, 4};
   int          cntMax[2]   = '{65535, 15};
   int          mPass[2];
   int          mFail[2];
   logic        mSeen[2];
   logic [3:0]  mCtrl[2];
   logic [31:0] mExp[2];
   logic [31:0] mAct[2];

   // per-instance views of the outputs
   logic        readyW[2];
   logic        doneW[2];
   logic        passW[2];
   logic        seenW[2];
   logic [31:0] passCntW[2];
   logic [31:0] failCntW[2];
   logic [31:0] fCtrlW[2];
   logic [31:0] fExpW[2];
   logic [31:0] fActW[2];

   assign readyW[0] = readyA;  assign readyW[1] = readyB;
   assign doneW[0]  = doneA;   assign doneW[1]  = doneB;
   assign passW[0]  = passA;   assign passW[1]  = passB;
   assign seenW[0]  = seenA;   assign seenW[1]  = seenB;
   assign passCntW[0] = 32'(passCntA);  assign passCntW[1] = 32'(passCntB);
   assign failCntW[0] = 32'(failCntA);  assign failCntW[1] = 32'(failCntB);
   assign fCtrlW[0] = 32'(fCtrlA);      assign fCtrlW[1] = 32'(fCtrlB);
   assign fExpW[0] = fExpA;   assign fExpW[1] = fExpB;
   assign fActW[0] = fActA;   assign fActW[1] = fActB;

   always #5 clk = ~clk;

   alu_checker #(.DUT_LATENCY(1), .CNT_W(16)) dutA (
      .clk(clk), .rst_n(rstN[0]), .chk_valid(valid[0]), .chk_ready(readyA),
      .chk_ctrl(chkCtrl), .chk_oper1(oper1), .chk_oper2(oper2),
      .dut_result(dutRes), .dut_overflow(dutOvf), .dut_zero(dutZero),
      .chk_done(doneA), .chk_pass(passA), .pass_cnt(passCntA), .fail_cnt(failCntA),
      .fail_seen(seenA), .fail_ctrl(fCtrlA), .fail_exp(fExpA), .fail_act(fActA)
   );

   alu_checker #(.DUT_LATENCY(4), .CNT_W(4)) dutB (
      .clk(clk), .rst_n(rstN[1]), .chk_valid(valid[1]), .chk_ready(readyB),
      .chk_ctrl(chkCtrl), .chk_oper1(oper1), .chk_oper2(oper2),
      .dut_result(dutRes), .dut_overflow(dutOvf), .dut_zero(dutZero),
      .chk_done(doneB), .chk_pass(passB), .pass_cnt(passCntB), .fail_cnt(failCntB),
      .fail_seen(seenB), .fail_ctrl(fCtrlB), .fail_exp(fExpB), .fail_act(fActB)
   );

   // Behavioural ALU: arithmetic on wide signed integers, overflow is
   // "true sum does not fit in 32 signed bits".
   function automatic void refModel(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o, output logic z);
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint s;
      longint maxPos = 64'sh7FFFFFFF;
      longint minNeg = -64'sh80000000;
      o = 1'b0;
      case (c)
         4'd0: begin s = sa + sb; r = s[31:0]; o = (s > maxPos) || (s < minNeg); end
         4'd1: begin s = sa - sb; r = s[31:0]; o = (s > maxPos) || (s < minNeg); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~(a | b);
         4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd7: r = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
         default: r = 32'h0;
      endcase
      z = (r == 32'h0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel(input int sel);
      mPass[sel] = 0;
      mFail[sel] = 0;
      mSeen[sel] = 1'b0;
      mCtrl[sel] = 4'h0;
      mExp[sel]  = 32'h0;
      mAct[sel]  = 32'h0;
   endtask

   task automatic checkState(input int sel);
      checkOutput("passCnt", passCntW[sel], 32'(mPass[sel]));
      checkOutput("failCnt", failCntW[sel], 32'(mFail[sel]));
      checkOutput("failSeen", 32'(seenW[sel]), 32'(mSeen[sel]));
      checkOutput("failCtrl", fCtrlW[sel], 32'(mCtrl[sel]));
      checkOutput("failExp", fExpW[sel], mExp[sel]);
      checkOutput("failAct", fActW[sel], mAct[sel]);
   endtask

   // Presents the operation at the current negedge and holds it through the
   // accept edge; afterwards ctrl/operands are scrambled.
   task automatic applyStimulus(input int sel, input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] dres,
                                input logic dovf, input logic dzero);
      chkCtrl = c;
      oper1   = a;
      oper2   = b;
      dutRes  = dres;
      dutOvf  = dovf;
      dutZero = dzero;
      valid[sel] = 1'b1;
      checkOutput("readyBeforeAccept", 32'(readyW[sel]), 32'd1);
      @(posedge clk);
      #1;
      valid[sel] = 1'b0;
      chkCtrl = 4'($urandom);
      oper1   = $urandom;
      oper2   = $urandom;
   endtask

   // One full operation; called just after a negedge, returns just after one.
   task automatic runOp(input int sel, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] dres,
                        input logic dovf, input logic dzero);
      logic [31:0] er;
      logic eo, ez;
      logic expPass;
      int lat;
      refModel(c, a, b, er, eo, ez);
      expPass = (dres === er) && (dovf === eo) && (dzero === ez);
      applyStimulus(sel, c, a, b, dres, dovf, dzero);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!doneW[sel] && lat < 40);
      checkOutput("doneSeen", 32'(doneW[sel]), 32'd1);
      checkOutput("latency", 32'(lat), 32'(latency[sel]));
      checkOutput("verdict", 32'(passW[sel]), 32'(expPass));
      if (expPass) begin
         if (mPass[sel] < cntMax[sel]) mPass[sel]++;
      end else begin
         if (mFail[sel] < cntMax[sel]) mFail[sel]++;
         if (!mSeen[sel]) begin
            mSeen[sel] = 1'b1;
            mCtrl[sel] = c;
            mExp[sel]  = er;
            mAct[sel]  = dres;
         end
      end
      @(negedge clk);
      checkOutput("doneOneCycle", 32'(doneW[sel]), 32'd0);
      checkOutput("readyAfter", 32'(readyW[sel]), 32'd1);
      checkState(sel);
   endtask

   task automatic runRandom(input int sel);
      logic [31:0] pick[5];
      logic [3:0]  c;
      logic [31:0] a, b, r;
      logic o, z;
      pick = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1};
      c = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      refModel(c, a, b, r, o, z);
      if ($urandom_range(0, 3) == 0) begin
         case ($urandom_range(0, 2))
            0: r = r ^ (32'h1 << $urandom_range(0, 31));
            1: o = ~o;
            default: z = ~z;
         endcase
      end
      runOp(sel, c, a, b, r, o, z);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      $display("[TB] start");
      rstN = 2'b00;
      valid = 2'b00;
      chkCtrl = 4'h0; oper1 = 32'h0; oper2 = 32'h0;
      dutRes = 32'h0; dutOvf = 1'b0; dutZero = 1'b0;
      resetModel(0);
      resetModel(1);
      repeat (3) @(negedge clk);
      checkOutput("rstReady", 32'(readyA), 32'd1);
      checkOutput("rstDone", 32'(doneA), 32'd0);
      checkOutput("rstPass", 32'(passA), 32'd0);
      checkState(0);
      checkState(1);
      rstN = 2'b11;

      // directed cases on the latency-1 instance
      runOp(0, 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
      runOp(0, 4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
      runOp(0, 4'd6, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 1'b0);
      runOp(0, 4'd7, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1);
      runOp(0, 4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
      runOp(0, 4'd3, 32'h0F0F0000, 32'h000000F0, 32'h12345678, 1'b0, 1'b0);
      runOp(0, 4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0);
      runOp(0, 4'd12, 32'hDEADBEEF, 32'h1234, 32'h0, 1'b0, 1'b1);
      runOp(0, 4'd5, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 1'b0, 1'b1);

      $display("[TB] random operations");
      for (int i = 0; i < 40; i++) runRandom(0);

      // latency-4 instance: reset during WAIT aborts the operation
      $display("[TB] reset abort on latency-4 instance");
      runOp(1, 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
      runOp(1, 4'd4, 32'hAAAA5555, 32'h5555AAAA, 32'h0, 1'b0, 1'b1);
      applyStimulus(1, 4'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("inWaitNotReady", 32'(readyB), 32'd0);
      #2;
      rstN[1] = 1'b0;
      #1;
      resetModel(1);
      checkOutput("abortReady", 32'(readyB), 32'd1);
      checkOutput("abortDone", 32'(doneB), 32'd0);
      checkState(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("abortNoDone", 32'(doneB), 32'd0);
      end
      rstN[1] = 1'b1;
      checkState(1);

      // saturation of the 4-bit pass counter
      $display("[TB] pass counter saturation");
      for (int i = 0; i < 18; i++) begin
         runOp(1, 4'd0, 32'(i), 32'd3, 32'(i + 3), 1'b0, 1'b0);
      end
      runOp(1, 4'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) runRandom(1);

      // latency-1 instance still consistent after more random traffic
      for (int i = 0; i < 10; i++) runRandom(0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
